// File: rtl/uart_word_tx.sv
// uart_word_tx
// Serialises one NB_DATA-bit word per handshake as 1..NB_DATA/NB_BYTE UART frames.
// Bytes go out least-significant first, and the block has its own baud tick generator.
// A bit lasts P = BAUD_DIV*OVERSAMPLE clocks.
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit is inserted between the data bits and the
//   stop bit, giving an 11-bit frame. When undefined, frames are plain 8N1.
//
// Ports:
//   i_clock     system clock, rising edge
//   i_reset     asynchronous active-low reset
//   i_valid     word request strobe
//   i_data      word to send, sampled at acceptance
//   i_n_bytes   number of bytes to send (1..4; 0 or >4 means 4), sampled at acceptance
//   o_ready     a word can be accepted this cycle
//   o_busy      a frame is on the line
//   o_byte_done one-cycle pulse in the last clock of each stop bit
//   o_word_done one-cycle pulse when the whole word has been sent
//   o_uart_tx   serial line, idle high
module uart_word_tx #(
    parameter int NB_DATA    = 32,
    parameter int NB_BYTE    = 8,
    parameter int BAUD_DIV   = 651,
    parameter int OVERSAMPLE = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    input  logic [2:0]         i_n_bytes,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_byte_done,
    output logic               o_word_done,
    output logic               o_uart_tx
);

    localparam int NUM_BYTES = NB_DATA / NB_BYTE;
    localparam int TW = (BAUD_DIV > 1)   ? $clog2(BAUD_DIV)   : 1;
    localparam int OW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (NB_BYTE > 1)    ? $clog2(NB_BYTE)    : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
    localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NB_BYTE - 1);
    localparam logic [2:0]    MAX_BYTES = 3'(NUM_BYTES);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Even parity over one data byte.
    function automatic logic even_parity(input logic [NB_BYTE-1:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;
`endif

    state_t               state_r, state_s;
    logic [TW-1:0]        tick_r, tick_s;
    logic [OW-1:0]        os_r, os_s;
    logic [BW-1:0]        bit_idx_r, bit_idx_s;
    logic [2:0]           byte_idx_r, byte_idx_s;
    logic [2:0]           n_bytes_r, n_bytes_s;
    logic [NB_DATA-1:0]   shift_r, shift_s;
`ifdef UART_TX_PARITY_EN
    logic                 parity_r, parity_s;
`endif
    logic                 uart_tx_r, uart_tx_s;
    logic                 ready_r, ready_s;
    logic                 busy_r, busy_s;
    logic                 byte_done_r, byte_done_s;
    logic                 word_done_r, word_done_s;
    logic                 accept_s;
    logic                 active_s;
    logic                 bit_end_s;
    logic [2:0]           n_clamp_s;

    // Handshake, bit-period boundary and byte-count clamp.
    always_comb begin
        accept_s  = i_valid & ready_r;
        active_s  = (state_r == ST_START) || (state_r == ST_DATA) ||
`ifdef UART_TX_PARITY_EN
                    (state_r == ST_PARITY) ||
`endif
                    (state_r == ST_STOP);
        bit_end_s = active_s && (tick_r == TICK_LAST) && (os_r == OS_LAST);
        if ((i_n_bytes == 3'd0) || (i_n_bytes > MAX_BYTES)) begin
            n_clamp_s = MAX_BYTES;
        end else begin
            n_clamp_s = i_n_bytes;
        end
    end

    // Baud tick and oversample counters; both restart on every acceptance.
    always_comb begin
        tick_s = tick_r;
        os_s   = os_r;
        if (accept_s) begin
            tick_s = '0;
            os_s   = '0;
        end else if (active_s) begin
            if (tick_r == TICK_LAST) begin
                tick_s = '0;
                if (os_r == OS_LAST) begin
                    os_s = '0;
                end else begin
                    os_s = os_r + OW'(1);
                end
            end else begin
                tick_s = tick_r + TW'(1);
            end
        end else begin
            tick_s = '0;
            os_s   = '0;
        end
    end

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_s    = state_r;
        bit_idx_s  = bit_idx_r;
        byte_idx_s = byte_idx_r;
        n_bytes_s  = n_bytes_r;
        shift_s    = shift_r;
`ifdef UART_TX_PARITY_EN
        parity_s   = parity_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_s    = ST_START;
                    shift_s    = i_data;
                    n_bytes_s  = n_clamp_s;
                    byte_idx_s = 3'd0;
                    bit_idx_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s   = ST_DATA;
                    bit_idx_s = '0;
`ifdef UART_TX_PARITY_EN
                    // The byte is still whole here; it is shifted out during DATA.
                    parity_s  = even_parity(shift_r[NB_BYTE-1:0]);
`endif
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    // Shifting one bit per data bit leaves the next byte at the LSBs.
                    shift_s = {1'b0, shift_r[NB_DATA-1:1]};
                    if (bit_idx_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + BW'(1);
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    if (byte_idx_r == (n_bytes_r - 3'd1)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s    = ST_START;
                        byte_idx_s = byte_idx_r + 3'd1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        case (state_s)
            ST_START: uart_tx_s = 1'b0;
            ST_DATA:  uart_tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: uart_tx_s = parity_s;
`endif
            default:  uart_tx_s = 1'b1;
        endcase
        ready_s     = (state_s == ST_IDLE) || (state_s == ST_DONE);
        busy_s      = ~ready_s;
        word_done_s = (state_s == ST_DONE);
        byte_done_s = (state_s == ST_STOP) && (tick_s == TICK_LAST) && (os_s == OS_LAST);
    end

    // State, counters, datapath and output registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= ST_IDLE;
            tick_r      <= '0;
            os_r        <= '0;
            bit_idx_r   <= '0;
            byte_idx_r  <= 3'd0;
            n_bytes_r   <= 3'd0;
            shift_r     <= '0;
`ifdef UART_TX_PARITY_EN
            parity_r    <= 1'b0;
`endif
            uart_tx_r   <= 1'b1;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            byte_done_r <= 1'b0;
            word_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            tick_r      <= tick_s;
            os_r        <= os_s;
            bit_idx_r   <= bit_idx_s;
            byte_idx_r  <= byte_idx_s;
            n_bytes_r   <= n_bytes_s;
            shift_r     <= shift_s;
`ifdef UART_TX_PARITY_EN
            parity_r    <= parity_s;
`endif
            uart_tx_r   <= uart_tx_s;
            ready_r     <= ready_s;
            busy_r      <= busy_s;
            byte_done_r <= byte_done_s;
            word_done_r <= word_done_s;
        end
    end

    assign o_ready     = ready_r;
    assign o_busy      = busy_r;
    assign o_byte_done = byte_done_r;
    assign o_word_done = word_done_r;
    assign o_uart_tx   = uart_tx_r;

endmodule

// File: tb/tb_uart_word_tx.sv
// Testbench for uart_word_tx with BAUD_DIV=2 and OVERSAMPLE=4, so one bit lasts 8 clocks.
// A behavioural model predicts every output for every cycle from the frame layout.
// Directed and random words are then decoded from the recorded line and checked
// against hand-computed values.
module tb_uart_word_tx;

    localparam int P = 8;
`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int HIST = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = 32'd0;
    logic [2:0]  i_n_bytes = 3'd0;
    logic        o_ready, o_busy, o_byte_done, o_word_done, o_uart_tx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic line_hist [0:HIST-1];
    int bd_q[$];

    uart_word_tx #(.NB_DATA(32), .NB_BYTE(8), .BAUD_DIV(2), .OVERSAMPLE(4)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_valid(i_valid), .i_data(i_data),
        .i_n_bytes(i_n_bytes), .o_ready(o_ready), .o_busy(o_busy),
        .o_byte_done(o_byte_done), .o_word_done(o_word_done), .o_uart_tx(o_uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < HIST) line_hist[cyc] = o_uart_tx;
        if (o_byte_done === 1'b1) bd_q.push_back(cyc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        e_tx = 1'b1, e_ready = 1'b1, e_busy = 1'b0, e_bd = 1'b0, e_wd = 1'b0;
    bit          m_active = 1'b0;
    int          m_pos = 0, m_len = 0, m_n = 0;
    logic [31:0] m_word = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
        end else begin
            if (e_ready && i_valid) begin
                m_word = i_data;
                m_n = (i_n_bytes == 3'd0 || i_n_bytes > 3'd4) ? 4 : int'(i_n_bytes);
                m_len = m_n * F * P;
                m_pos = 0;
                m_active = 1'b1;
            end else if (m_active) begin
                m_pos++;
                if (m_pos > m_len) m_active = 1'b0;
            end
        end
        if (!m_active) begin
            e_tx = 1'b1; e_ready = 1'b1; e_busy = 1'b0; e_bd = 1'b0; e_wd = 1'b0;
        end else if (m_pos == m_len) begin
            e_tx = 1'b1; e_ready = 1'b1; e_busy = 1'b0; e_bd = 1'b0; e_wd = 1'b1;
        end else begin
            int k, r, b;
            logic [7:0] mb;
            k = m_pos / (F * P);
            r = m_pos % (F * P);
            b = r / P;
            mb = 8'((m_word >> (8 * k)) & 32'hFF);
            if (b == 0) e_tx = 1'b0;
            else if (b <= 8) e_tx = mb[b-1];
            else if (F == 11 && b == 9) e_tx = ^mb;
            else e_tx = 1'b1;
            e_bd = (r == F * P - 1);
            e_ready = 1'b0; e_busy = 1'b1; e_wd = 1'b0;
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        chk("cycle_outputs{tx,ready,busy,byte_done,word_done}",
            {27'd0, o_uart_tx, o_ready, o_busy, o_byte_done, o_word_done},
            {27'd0, e_tx, e_ready, e_busy, e_bd, e_wd});
    end

    // ---------------- helpers ----------------
    task automatic send(input logic [31:0] d, input logic [2:0] n, output int acc);
        @(negedge clk);
        i_valid = 1'b1; i_data = d; i_n_bytes = n;
        @(posedge clk); #1;
        acc = cyc;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_wd(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_word_done === 1'b1) begin
                when = cyc;
                break;
            end
        end
        if (when < 0) begin
            checks++; failures++;
            $display("FAIL word_done_timeout actual=none required=pulse within %0d cycles", budget);
        end
    endtask

    function automatic logic [7:0] rx_byte(input int acc, input int k);
        logic [7:0] v;
        v = 8'd0;
        for (int j = 0; j < 8; j++) begin
            int idx;
            idx = acc + k * F * P + (1 + j) * P + P / 2;
            if (idx < HIST) v[j] = line_hist[idx];
        end
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, acc2, w;
        logic [9:0] bits;
        logic [31:0] d;
        logic [2:0] n;
        int ne;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_tx", {31'd0, o_uart_tx}, 32'd1);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_pulses", {30'd0, o_byte_done, o_word_done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Four-byte word, LSB first
        bd_q.delete();
        send(32'hAABBCCDD, 3'd4, acc);
        wait_wd(400, w);
        chk("n4_duration", w - acc, 32'd4 * F * P);
        for (int b = 0; b < 10; b++) bits[b] = line_hist[acc + b * P + P / 2];
`ifdef UART_TX_PARITY_EN
        chk("dd_bits", {22'd0, bits}, {22'd0, 10'b0110111010});
`else
        chk("dd_bits", {22'd0, bits}, {22'd0, 10'b1110111010});
`endif
        chk("byte0", {24'd0, rx_byte(acc, 0)}, 32'hDD);
        chk("byte1", {24'd0, rx_byte(acc, 1)}, 32'hCC);
        chk("byte2", {24'd0, rx_byte(acc, 2)}, 32'hBB);
        chk("byte3", {24'd0, rx_byte(acc, 3)}, 32'hAA);
        chk("byte_done_count", bd_q.size(), 32'd4);
        if (bd_q.size() == 4) begin
            chk("byte_done_first", bd_q[0] - acc, F * P - 1);
            for (int i = 1; i < 4; i++) chk("byte_done_spacing", bd_q[i] - bd_q[i-1], F * P);
        end

        // Single byte, and clamped counts 0 and 7
        send(32'h00110011, 3'd1, acc);
        wait_wd(200, w);
        chk("n1_duration", w - acc, F * P);
        chk("n1_byte", {24'd0, rx_byte(acc, 0)}, 32'h11);
        send(32'h12345678, 3'd0, acc);
        wait_wd(400, w);
        chk("n0_duration", w - acc, 4 * F * P);
        chk("n0_byte3", {24'd0, rx_byte(acc, 3)}, 32'h12);
        send(32'h9ABCDEF0, 3'd7, acc);
        wait_wd(400, w);
        chk("n7_duration", w - acc, 4 * F * P);

        // Requests while busy are ignored; request in the DONE cycle starts immediately
        send(32'h01020304, 3'd4, acc);
        i_valid = 1'b1; i_data = 32'h44444444; i_n_bytes = 3'd4;
        repeat (100) @(negedge clk);
        i_valid = 1'b0;
        wait_wd(400, w);
        chk("busy_duration", w - acc, 4 * F * P);
        chk("busy_byte0", {24'd0, rx_byte(acc, 0)}, 32'h04);
        chk("busy_byte3", {24'd0, rx_byte(acc, 3)}, 32'h01);
        i_valid = 1'b1; i_data = 32'hB0B0B0B0; i_n_bytes = 3'd4;
        @(posedge clk); #1;
        acc2 = cyc;
        @(negedge clk);
        i_valid = 1'b0;
        chk("b2b_gap", acc2 - w, 32'd1);
        chk("b2b_start_bit", {31'd0, o_uart_tx}, 32'd0);
        wait_wd(400, w);
        chk("b2b_duration", w - acc2, 4 * F * P);
        for (int k = 0; k < 4; k++) chk("b2b_byte", {24'd0, rx_byte(acc2, k)}, 32'hB0);

        // Reset in the middle of data bit 3
        send(32'h000000F7, 3'd1, acc);
        repeat (4 * P + 2) @(negedge clk);
        chk("pre_reset_bit3", {31'd0, o_uart_tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_tx", {31'd0, o_uart_tx}, 32'd1);
        chk("mid_reset_ready", {31'd0, o_ready}, 32'd1);
        chk("mid_reset_busy", {31'd0, o_busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bd_q.delete();
        send(32'h00110011, 3'd1, acc);
        wait_wd(200, w);
        chk("post_reset_duration", w - acc, F * P);
        chk("post_reset_byte", {24'd0, rx_byte(acc, 0)}, 32'h11);
        chk("post_reset_byte_done", bd_q.size(), 32'd1);

`ifdef UART_TX_PARITY_EN
        send(32'h000000B0, 3'd1, acc);
        wait_wd(200, w);
        chk("parity_duration", w - acc, 32'd88);
        chk("parity_bit", {31'd0, line_hist[acc + 9 * P + P / 2]}, 32'd1);
        chk("parity_stop", {31'd0, line_hist[acc + 10 * P + P / 2]}, 32'd1);
`endif

        // Random words with junk requests while busy
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            d = $urandom;
            n = 3'($urandom_range(0, 7));
            ne = (n == 3'd0 || n > 3'd4) ? 4 : int'(n);
            send(d, n, acc);
            for (int j = 0; j < int'($urandom_range(0, 30)); j++) begin
                @(negedge clk);
                i_valid = 1'($urandom % 2);
                i_data = $urandom;
                i_n_bytes = 3'($urandom);
            end
            i_valid = 1'b0;
            wait_wd(400, w);
            chk("rand_duration", w - acc, ne * F * P);
            for (int k = 0; k < ne; k++)
                chk("rand_byte", {24'd0, rx_byte(acc, k)}, (d >> (8 * k)) & 32'hFF);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
